// File: rtl/piped_adder.sv
// piped_adder: R-stage carry-segmented pipelined adder.
//
// Computes {cout0, out0} = in0 + in1 + cin0 (unsigned, W+1 bits). The result
// appears R clocks after the operands are sampled. A new operand set is
// accepted on every cycle.
//
// The operands are cut into R segments of ceil(W/R) bits, and the last
// segment takes the remainder. Segment k is added in stage k, using the
// registered carry from stage k-1.
// - Operand segments are delayed (skewed) so that they meet their carry.
// - Sum segments are delayed (deskewed) so that one whole result leaves
//   together.
// - When R = 1 this reduces to a plain registered adder.
//
// Parameters:
//   W  operand/sum width (>= 1)
//   R  pipeline stages / carry segments (1 <= R <= W)
//   C  1: registered carry-out, 0: cout0 held at 0
//   M  sideband width (>= 1)
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-low reset; clears all pipeline state
//   cin0   carry-in
//   in0    first addend  (W)
//   in1    second addend (W)
//   out0   registered sum (W)
//   cout0  registered carry-out
//   m_i    sideband in  (M), passed through R registers unchanged
//   m_o    sideband out (M), aligned with out0
module piped_adder #(
  parameter int W = 32,
  parameter int R = 1,
  parameter int C = 1,
  parameter int M = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cin0,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out0,
  output logic         cout0,
  input  logic [M-1:0] m_i,
  output logic [M-1:0] m_o
);

  localparam int SEG = (W + R - 1) / R;

  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : gen_seg
      // Segment bounds are clipped to W. When ceil(W/R)*R exceeds W,
      // trailing segments can be empty. An empty segment only forwards
      // the carry, so the latency stays the same.
      localparam int LO = (gi * SEG < W) ? gi * SEG : W;
      localparam int HI = ((gi + 1) * SEG < W) ? (gi + 1) * SEG : W;
      localparam int SW = HI - LO;
      localparam int DL = R - 1 - gi;
      // The final carry is only kept when a carry-out is wanted. Otherwise
      // it loads constant 0, so cout0 reads 0 in every cycle.
      localparam bit KEEP_CARRY = (gi < R - 1) || (C != 0);

      logic c_in;
      logic carry_reg;

      if (gi == 0) begin : gen_cin_port
        assign c_in = cin0;
      end else begin : gen_cin_stage
        assign c_in = gen_seg[gi-1].carry_reg;
      end

      if (SW > 0) begin : gen_bits
        logic [SW-1:0] a_seg;
        logic [SW-1:0] b_seg;
        logic [SW:0]   seg_sum;
        logic [SW-1:0] sum_seg_reg;
        logic [SW-1:0] sum_seg_out;

        // Skew: segment gi waits gi cycles for its incoming carry.
        if (gi == 0) begin : gen_noskew
          assign a_seg = in0[HI-1:LO];
          assign b_seg = in1[HI-1:LO];
        end else begin : gen_skew
          logic [gi-1:0][SW-1:0] a_skew_reg;
          logic [gi-1:0][SW-1:0] b_skew_reg;
          always_ff @(posedge clk) begin
            if (!rst) begin
              a_skew_reg <= '0;
              b_skew_reg <= '0;
            end else begin
              a_skew_reg[0] <= in0[HI-1:LO];
              b_skew_reg[0] <= in1[HI-1:LO];
              for (int i = 1; i < gi; i++) begin
                a_skew_reg[i] <= a_skew_reg[i-1];
                b_skew_reg[i] <= b_skew_reg[i-1];
              end
            end
          end
          assign a_seg = a_skew_reg[gi-1];
          assign b_seg = b_skew_reg[gi-1];
        end

        assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SW{1'b0}}, c_in};

        always_ff @(posedge clk) begin
          if (!rst) begin
            sum_seg_reg <= '0;
            carry_reg   <= 1'b0;
          end else begin
            sum_seg_reg <= seg_sum[SW-1:0];
            carry_reg   <= KEEP_CARRY ? seg_sum[SW] : 1'b0;
          end
        end

        // Deskew: early segments are held until the last segment is done.
        if (DL == 0) begin : gen_nodeskew
          assign sum_seg_out = sum_seg_reg;
        end else begin : gen_deskew
          logic [DL-1:0][SW-1:0] sum_dly_reg;
          always_ff @(posedge clk) begin
            if (!rst) begin
              sum_dly_reg <= '0;
            end else begin
              sum_dly_reg[0] <= sum_seg_reg;
              for (int i = 1; i < DL; i++) begin
                sum_dly_reg[i] <= sum_dly_reg[i-1];
              end
            end
          end
          assign sum_seg_out = sum_dly_reg[DL-1];
        end

        assign out0[HI-1:LO] = sum_seg_out;
      end else begin : gen_empty
        always_ff @(posedge clk) begin
          if (!rst) begin
            carry_reg <= 1'b0;
          end else begin
            carry_reg <= KEEP_CARRY ? c_in : 1'b0;
          end
        end
      end
    end
  endgenerate

  assign cout0 = gen_seg[R-1].carry_reg;

  // Sideband delay line, R deep, so that it stays aligned with out0.
  logic [R-1:0][M-1:0] m_reg;
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_reg <= '0;
    end else begin
      m_reg[0] <= m_i;
      for (int i = 1; i < R; i++) begin
        m_reg[i] <= m_reg[i-1];
      end
    end
  end
  assign m_o = m_reg[R-1];

endmodule

// File: tb/tb_piped_adder.sv
// tb_piped_adder: directed and table-driven checks of piped_adder in several
// parameterisations (W8/R1, W8/R1/C0, W16/R4, W13/R3, W384/R1).
module tb_piped_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // W=8 R=1 C=1 M=1
  logic [7:0] a8, b8, o8;
  logic       cin8, co8, mi8, mo8;
  // W=8 R=1 C=0 M=1
  logic [7:0] ac, bc, oc;
  logic       cinc, coc, mic, moc;
  // W=16 R=4 M=4
  logic [15:0] a16, b16, o16;
  logic        cin16, co16;
  logic [3:0]  mi16, mo16;
  // W=13 R=3 M=8
  logic [12:0] a13, b13, o13;
  logic        cin13, co13;
  logic [7:0]  mi13, mo13;
  // W=384 R=1 M=1
  logic [383:0] a384, b384, o384;
  logic         cin384, co384, mi384, mo384;

  piped_adder #(.W(8), .R(1), .C(1), .M(1)) u8 (
    .clk(clk), .rst(rst), .cin0(cin8), .in0(a8), .in1(b8),
    .out0(o8), .cout0(co8), .m_i(mi8), .m_o(mo8));
  piped_adder #(.W(8), .R(1), .C(0), .M(1)) u8c0 (
    .clk(clk), .rst(rst), .cin0(cinc), .in0(ac), .in1(bc),
    .out0(oc), .cout0(coc), .m_i(mic), .m_o(moc));
  piped_adder #(.W(16), .R(4), .C(1), .M(4)) u16 (
    .clk(clk), .rst(rst), .cin0(cin16), .in0(a16), .in1(b16),
    .out0(o16), .cout0(co16), .m_i(mi16), .m_o(mo16));
  piped_adder #(.W(13), .R(3), .C(1), .M(8)) u13 (
    .clk(clk), .rst(rst), .cin0(cin13), .in0(a13), .in1(b13),
    .out0(o13), .cout0(co13), .m_i(mi13), .m_o(mo13));
  piped_adder #(.W(384), .R(1), .C(1), .M(1)) u384 (
    .clk(clk), .rst(rst), .cin0(cin384), .in0(a384), .in1(b384),
    .out0(o384), .cout0(co384), .m_i(mi384), .m_o(mo384));

  typedef struct {
    logic [7:0] a, b;
    logic       cin, m;
    logic [7:0] sum;
    logic       cout;
  } vec8_t;

  typedef struct {
    logic [15:0] a, b;
    logic        cin;
    logic [3:0]  m;
    logic [15:0] sum;
    logic        cout;
  } vec16_t;

  vec8_t  v8  [7];
  vec16_t v16 [6];
  logic [13:0] exp13  [1000];
  logic [7:0]  expm13 [1000];

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic zero_inputs();
    a8 = '0;   b8 = '0;   cin8 = 0;   mi8 = 0;
    ac = '0;   bc = '0;   cinc = 0;   mic = 0;
    a16 = '0;  b16 = '0;  cin16 = 0;  mi16 = '0;
    a13 = '0;  b13 = '0;  cin13 = 0;  mi13 = '0;
    a384 = '0; b384 = '0; cin384 = 0; mi384 = 0;
  endtask

  task automatic drive_busy();
    a8 = 8'hFF;    b8 = 8'hFF;    cin8 = 1;   mi8 = 1;
    ac = 8'hFF;    bc = 8'hFF;    cinc = 1;   mic = 1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1; mi16 = 4'hF;
    a13 = '1;      b13 = '1;      cin13 = 1;  mi13 = 8'hFF;
    a384 = '1;     b384 = '1;     cin384 = 1; mi384 = 1;
  endtask

  initial begin
    // {a, b, cin, m, sum, cout}
    v8[0] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1};
    v8[1] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
    v8[2] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
    v8[3] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0};
    v8[4] = '{8'h80, 8'h7F, 1'b1, 1'b1, 8'h00, 1'b1};
    v8[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
    v8[6] = '{8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0};

    v16[0] = '{16'hFFFF, 16'h0000, 1'b1, 4'h1, 16'h0000, 1'b1};
    v16[1] = '{16'h00FF, 16'h0001, 1'b0, 4'h2, 16'h0100, 1'b0};
    v16[2] = '{16'h0F0F, 16'hF0F1, 1'b0, 4'h3, 16'h0000, 1'b1};
    v16[3] = '{16'h1234, 16'h4321, 1'b1, 4'h4, 16'h5556, 1'b0};
    v16[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 4'h5, 16'hFFFF, 1'b1};
    v16[5] = '{16'h8000, 16'h8000, 1'b0, 4'h6, 16'h0000, 1'b1};

    // Reset with busy inputs: every output must still read 0.
    rst = 1'b0;
    drive_busy();
    step();
    step();
    chk("rst_u8_out", 384'(o8), 0);
    chk("rst_u8_cout_m", 384'({co8, mo8}), 0);
    chk("rst_u16_all", 384'({co16, mo16, o16}), 0);
    chk("rst_u13_all", 384'({co13, mo13, o13}), 0);
    chk("rst_u384_out", o384, 0);
    chk("rst_u384_cout_m", 384'({co384, mo384}), 0);
    $display("reset: outputs cleared");

    rst = 1'b1;
    zero_inputs();
    for (int i = 0; i < 4; i++) step();

    // R=1 table: the result is visible after the sampling edge.
    for (int i = 0; i < 7; i++) begin
      a8 = v8[i].a; b8 = v8[i].b; cin8 = v8[i].cin; mi8 = v8[i].m;
      ac = v8[i].a; bc = v8[i].b; cinc = v8[i].cin; mic = v8[i].m;
      step();
      chk($sformatf("u8_sum[%0d]", i), 384'(o8), 384'(v8[i].sum));
      chk($sformatf("u8_cout[%0d]", i), 384'(co8), 384'(v8[i].cout));
      chk($sformatf("u8_m[%0d]", i), 384'(mo8), 384'(v8[i].m));
      chk($sformatf("c0_sum[%0d]", i), 384'(oc), 384'(v8[i].sum));
      chk($sformatf("c0_cout[%0d]", i), 384'(coc), 0);
      $display("u8 %02h+%02h+%0d -> %02h c%0d (c0: %02h c%0d)",
               v8[i].a, v8[i].b, v8[i].cin, o8, co8, oc, coc);
    end
    zero_inputs();
    step();

    // R=4 latency: FFFF+0+1 ripples across every segment boundary.
    a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1; mi16 = 4'h5;
    step();
    zero_inputs();
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("u16_early_cout[%0d]", k), 384'(co16), 0);
      chk($sformatf("u16_early_m[%0d]", k), 384'(mo16), 0);
      step();
    end
    chk("u16_lat_out", 384'(o16), 0);
    chk("u16_lat_cout", 384'(co16), 1);
    chk("u16_lat_m", 384'(mo16), 5);
    $display("u16 FFFF+0000+1 -> %04h c%0d m%0h after 4 edges", o16, co16, mo16);
    step();
    chk("u16_after_lat", 384'({co16, mo16}), 0);

    // R=4 table issued back-to-back.
    for (int t = 0; t < 9; t++) begin
      if (t < 6) begin
        a16 = v16[t].a; b16 = v16[t].b; cin16 = v16[t].cin; mi16 = v16[t].m;
      end else begin
        zero_inputs();
      end
      step();
      if (t >= 3) begin
        chk($sformatf("u16_sum[%0d]", t - 3), 384'(o16), 384'(v16[t-3].sum));
        chk($sformatf("u16_cout[%0d]", t - 3), 384'(co16), 384'(v16[t-3].cout));
        chk($sformatf("u16_m[%0d]", t - 3), 384'(mo16), 384'(v16[t-3].m));
        $display("u16 op%0d -> %04h c%0d m%0h", t - 3, o16, co16, mo16);
      end
    end

    // W=13 R=3 uneven segments, random operands every cycle.
    for (int t = 0; t < 1002; t++) begin
      if (t < 1000) begin
        a13 = 13'($urandom); b13 = 13'($urandom);
        cin13 = 1'($urandom); mi13 = 8'($urandom);
        exp13[t]  = {1'b0, a13} + {1'b0, b13} + {13'd0, cin13};
        expm13[t] = mi13;
      end else begin
        zero_inputs();
      end
      step();
      if (t >= 2) begin
        chk($sformatf("u13_sum[%0d]", t - 2), 384'({co13, o13}), 384'(exp13[t-2]));
        chk($sformatf("u13_m[%0d]", t - 2), 384'(mo13), 384'(expm13[t-2]));
      end
    end
    $display("u13 random run: 1000 operations compared");

    // W=384 boundaries.
    zero_inputs();
    a384 = '1; b384 = 384'd1;
    step();
    chk("u384_out_wrap", o384, 0);
    chk("u384_cout_wrap", 384'(co384), 1);
    $display("u384 ones+1 -> cout %0d", co384);
    a384 = '1; b384 = '1; cin384 = 1;
    step();
    chk("u384_out_max", o384, {384{1'b1}});
    chk("u384_cout_max", 384'(co384), 1);
    $display("u384 ones+ones+1 -> cout %0d", co384);
    zero_inputs();

    // One-cycle reset while four R=4 operations are in flight.
    for (int t = 0; t < 4; t++) begin
      a16 = v16[t].a; b16 = v16[t].b; cin16 = v16[t].cin; mi16 = v16[t].m;
      step();
    end
    rst = 1'b0;
    drive_busy();
    step();
    chk("midrst_u16", 384'({co16, mo16, o16}), 0);
    chk("midrst_u8", 384'({co8, mo8, o8}), 0);
    chk("midrst_u13", 384'({co13, mo13, o13}), 0);
    $display("mid-op reset: outputs cleared");
    rst = 1'b1;
    zero_inputs();
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1; mi16 = 4'h9;
    step();
    zero_inputs();
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("postrst_flushed[%0d]", k), 384'({co16, mo16, o16}), 0);
      step();
    end
    chk("postrst_sum", 384'(o16), 384'(16'h5556));
    chk("postrst_cout", 384'(co16), 0);
    chk("postrst_m", 384'(mo16), 9);
    $display("post-reset u16 1234+4321+1 -> %04h c%0d m%0h", o16, co16, mo16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
